// File: rtl/led_pattern_pkg.sv
// Shared mode and channel-state encodings for the multi-channel LED pattern generator.
package led_pattern_pkg;

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_BURST = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HI   = 2'd1;
    localparam logic [1:0] ST_LO   = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    // A burst with zero pulses parks in GAP so the LED never lights.
    function automatic logic [1:0] start_state(input logic [1:0] mode, input logic burst_zero);
        case (mode)
            MODE_OFF:   start_state = ST_IDLE;
            MODE_BURST: start_state = burst_zero ? ST_GAP : ST_HI;
            default:    start_state = ST_HI;
        endcase
    endfunction

endpackage

// File: rtl/led_pattern_ctrl_channel.sv
// One LED channel: config registers, pattern state, phase/pulse counters and registered led bit.
module led_pattern_ctrl_channel
    import led_pattern_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int BURST_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               tick,
    input  logic               wr,
    input  logic [1:0]         wr_mode,
    input  logic [CNT_W-1:0]   wr_half,
    input  logic [BURST_W-1:0] wr_burst,
    input  logic [CNT_W-1:0]   wr_gap,
    output logic               led
);

    logic [1:0]         mode, state, nxt_state;
    logic [CNT_W-1:0]   half, gap, phase, nxt_phase, half_len, last_cnt;
    logic [BURST_W-1:0] burst, pulses, nxt_pulses;

    always_comb begin
        half_len   = (half == '0) ? CNT_W'(1) : half;
        last_cnt   = (state == ST_GAP) ? gap - CNT_W'(1) : half_len - CNT_W'(1);
        nxt_state  = state;
        nxt_phase  = phase;
        nxt_pulses = pulses;
        if (wr) begin
            nxt_state  = start_state(wr_mode, wr_burst == '0);
            nxt_phase  = '0;
            nxt_pulses = '0;
        end else if (!en) begin
            nxt_state  = start_state(mode, burst == '0);
            nxt_phase  = '0;
            nxt_pulses = '0;
        end else if (tick && (mode == MODE_BLINK || mode == MODE_BURST)) begin
            if (phase == last_cnt) begin
                nxt_phase = '0;
                case (state)
                    ST_HI: nxt_state = ST_LO;
                    ST_LO: begin
                        if (mode == MODE_BLINK) begin
                            nxt_state = ST_HI;
                        end else if ((pulses + BURST_W'(1)) == burst) begin
                            nxt_pulses = '0;
                            nxt_state  = (gap == '0) ? ST_HI : ST_GAP;
                        end else begin
                            nxt_pulses = pulses + BURST_W'(1);
                            nxt_state  = ST_HI;
                        end
                    end
                    ST_GAP:  nxt_state = (burst == '0) ? ST_GAP : ST_HI;
                    default: nxt_state = state;
                endcase
            end else begin
                nxt_phase = phase + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode   <= MODE_OFF;
            half   <= '0;
            burst  <= '0;
            gap    <= '0;
            state  <= ST_IDLE;
            phase  <= '0;
            pulses <= '0;
            led    <= 1'b0;
        end else begin
            if (wr) begin
                mode  <= wr_mode;
                half  <= wr_half;
                burst <= wr_burst;
                gap   <= wr_gap;
            end
            state  <= nxt_state;
            phase  <= nxt_phase;
            pulses <= nxt_pulses;
            led    <= en && (nxt_state == ST_HI);
        end
    end

endmodule

// File: rtl/led_pattern_ctrl.sv
// Multi-channel LED pattern generator: shared tick prescaler, config write decode, global enable.
module led_pattern_ctrl
    import led_pattern_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int TICK_HZ     = 1000,
    parameter int CNT_W       = 16,
    parameter int BURST_W     = 4,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               cfg_we,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [1:0]         cfg_mode,
    input  logic [CNT_W-1:0]   cfg_half,
    input  logic [BURST_W-1:0] cfg_burst,
    input  logic [CNT_W-1:0]   cfg_gap,
    output logic [NUM_CH-1:0]  led
);

    localparam int TICK_DIV = CLK_FREQ_HZ / TICK_HZ;
    localparam int DIV_W    = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] presc;
    logic             tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  presc <= '0;
        else if (!enable)         presc <= '0;
        else if (presc == DIV_LAST) presc <= '0;
        else                      presc <= presc + DIV_W'(1);
    end

    assign tick = enable && (presc == DIV_LAST);

    // Exact match against the channel index; out-of-range cfg_ch hits no channel.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        led_pattern_ctrl_channel #(
            .CNT_W   (CNT_W),
            .BURST_W (BURST_W)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .en       (enable),
            .tick     (tick),
            .wr       (cfg_we && (cfg_ch == CH_W'(i))),
            .wr_mode  (cfg_mode),
            .wr_half  (cfg_half),
            .wr_burst (cfg_burst),
            .wr_gap   (cfg_gap),
            .led      (led[i])
        );
    end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Scoreboard bench: a tick-count pattern model predicts led every clk; a monitor compares.
module tb_led_pattern_ctrl;

    localparam int NUM_CH   = 5;
    localparam int CNT_W    = 16;
    localparam int BURST_W  = 4;
    localparam int TICK_DIV = 10;
    localparam int CH_W     = 3;

    logic               clk, rst, enable, cfg_we;
    logic [CH_W-1:0]    cfg_ch;
    logic [1:0]         cfg_mode;
    logic [CNT_W-1:0]   cfg_half, cfg_gap;
    logic [BURST_W-1:0] cfg_burst;
    logic [NUM_CH-1:0]  led;

    led_pattern_ctrl #(
        .NUM_CH(NUM_CH), .CLK_FREQ_HZ(1000), .TICK_HZ(100), .CNT_W(CNT_W), .BURST_W(BURST_W)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode), .cfg_half(cfg_half), .cfg_burst(cfg_burst), .cfg_gap(cfg_gap),
        .led(led)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: each channel's LED is a pure function of config and ticks since restart.
    int m_mode[NUM_CH], m_half[NUM_CH], m_burst[NUM_CH], m_gap[NUM_CH], m_t[NUM_CH];
    int m_presc;
    logic [NUM_CH-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic bit pattern(input int mode, input int h, input int b, input int g, input int t);
        int hh, pos;
        hh = (h == 0) ? 1 : h;
        case (mode)
            0: return 1'b0;
            1: return 1'b1;
            2: return ((t / hh) % 2) == 0;
            default: begin
                if (b == 0) return 1'b0;
                pos = t % (2 * hh * b + g);
                return (pos < 2 * hh * b) && (((pos / hh) % 2) == 0);
            end
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [NUM_CH-1:0] e;
        bit tk;
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_mode[c] = 0; m_half[c] = 0; m_burst[c] = 0; m_gap[c] = 0; m_t[c] = 0;
            end
            m_presc = 0;
            exp_q.delete();
            exp_q.push_back('0);
        end else begin
            tk = enable && (m_presc == TICK_DIV - 1);
            for (int c = 0; c < NUM_CH; c++) begin
                if (cfg_we && int'(cfg_ch) == c) begin
                    m_mode[c] = int'(cfg_mode); m_half[c] = int'(cfg_half);
                    m_burst[c] = int'(cfg_burst); m_gap[c] = int'(cfg_gap);
                    m_t[c] = 0;
                end else if (!enable) m_t[c] = 0;
                else if (tk) m_t[c]++;
                e[c] = enable && pattern(m_mode[c], m_half[c], m_burst[c], m_gap[c], m_t[c]);
            end
            m_presc = !enable ? 0 : (m_presc == TICK_DIV - 1) ? 0 : m_presc + 1;
            exp_q.push_back(e);
        end
    end

    // Monitor: also wakes on rst so the asynchronous clear is checked mid-cycle.
    always begin
        logic [NUM_CH-1:0] e;
        @(negedge clk or posedge rst);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (led !== e) begin
                n_bad++;
                $display("FAIL led t=%0t got %b expected %b", $time, led, e);
            end
        end
    end

    task automatic wr(input int ch, input int m, input int h, input int b, input int g);
        cfg_we = 1'b1; cfg_ch = CH_W'(ch); cfg_mode = 2'(m);
        cfg_half = CNT_W'(h); cfg_burst = BURST_W'(b); cfg_gap = CNT_W'(g);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic align_tick();
        for (int k = 0; k < 2 * TICK_DIV && m_presc != TICK_DIV - 1; k++) @(negedge clk);
        if (m_presc != TICK_DIV - 1) begin
            $display("FAIL tick_align: prescaler never reached %0d", TICK_DIV - 1);
            $fatal(1);
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0;
        cfg_half = '0; cfg_burst = '0; cfg_gap = '0;
        idle(3);
        rst = 1'b0;
        idle(4);
        wr(0, 1, 0, 0, 0); idle(3);        // ON then OFF
        wr(0, 0, 0, 0, 0); idle(3);
        wr(1, 2, 3, 0, 0); idle(130);      // BLINK half=3
        wr(1, 2, 0, 0, 0); idle(50);       // half=0 acts as 1
        wr(1, 2, 3, 0, 0); idle(20);
        wr(2, 3, 1, 2, 4); idle(200);      // BURST 2 pulses, gap 4
        wr(2, 3, 1, 0, 4); idle(50);       // burst=0 stays dark
        enable = 1'b0; idle(25);
        enable = 1'b1; idle(80);
        align_tick();
        wr(3, 2, 2, 0, 0); idle(60);       // write coincident with a tick
        wr(5, 1, 0, 0, 0); idle(20);       // out-of-range channel
        wr(6, 1, 0, 0, 0); idle(10);
        wr(0, 1, 0, 0, 0); wr(2, 3, 2, 3, 1); wr(4, 3, 1, 1, 0); idle(37);
        @(posedge clk); #2 rst = 1'b1;     // mid-cycle async reset
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        idle(40);
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 10)
                wr($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 4),
                   $urandom_range(0, 3), $urandom_range(0, 5));
            else begin
                if (r < 12 || (!enable && r < 25)) enable = ~enable;
                @(negedge clk);
            end
        end
        enable = 1'b1;
        idle(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
